lab4_ram_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the lab4 polynomial-result RAM (16 × 9-bit entries, written from a 5-bit coefficient word plus op/argument select). It accepts read and write commands from two independent requesters (A and B), grants the single RAM port to one requester at a time, and sequences the RAM's synchronous write and combinational read. It returns read data and a one-cycle acknowledge to the winning requester. It sits between the lab4 control logic / test drivers and `lab4RAM`, whose ports it drives directly.

---
 rtl/lab4_ram_arbiter_if.sv | 41 ++++
 rtl/lab4_ram_arbiter.sv | 149 ++++++++++++++
 tb/tb_lab4_ram_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/lab4_ram_arbiter_if.sv
// Requester and RAM-side signals of the lab4 RAM arbiter.
// The slave modport belongs to the arbiter. The master modport belongs to the requesters and the RAM model.
interface lab4_ram_arbiter_if;
  logic       reqA;
  logic       reqB;
  logic       wrA;
  logic       wrB;
  logic [3:0] addrA;
  logic [3:0] addrB;
  logic [4:0] dataA;
  logic [4:0] dataB;
  logic       opA;
  logic       opB;
  logic [1:0] argA;
  logic [1:0] argB;
  logic       ackA;
  logic       ackB;
  logic [8:0] rdataA;
  logic [8:0] rdataB;
  logic       busy;
  logic       ramMode;
  logic [3:0] ramAddr;
  logic [4:0] ramInput;
  logic       ramOp;
  logic [1:0] ramArg;
  logic [8:0] ramOutput;

  modport slave (
    input  reqA, reqB, wrA, wrB, addrA, addrB, dataA, dataB,
           opA, opB, argA, argB, ramOutput,
    output ackA, ackB, rdataA, rdataB, busy,
           ramMode, ramAddr, ramInput, ramOp, ramArg
  );

  modport master (
    output reqA, reqB, wrA, wrB, addrA, addrB, dataA, dataB,
           opA, opB, argA, argB, ramOutput,
    input  ackA, ackB, rdataA, rdataB, busy,
           ramMode, ramAddr, ramInput, ramOp, ramArg
  );
endinterface

// File: rtl/lab4_ram_arbiter.sv
// Two-requester arbiter and sequencer in front of lab4RAM (IDLE -> ISSUE -> ACK).
// Define LAB4_ARB_FIXED_PRIO_EN for fixed priority (A always wins). The default build is round-robin.
module lab4_ram_arbiter (
  input logic               CLK,
  input logic               RESET_N,
  lab4_ram_arbiter_if.slave bus
);

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 5;
  localparam int unsigned GW = 2;
  localparam int unsigned OW = 9;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  logic [1:0]    state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          cmd_wr_q, cmd_wr_d;
  logic [AW-1:0] cmd_addr_q, cmd_addr_d;
  logic [DW-1:0] cmd_data_q, cmd_data_d;
  logic          cmd_op_q, cmd_op_d;
  logic [GW-1:0] cmd_arg_q, cmd_arg_d;
  logic          ram_mode_q, ram_mode_d;
  logic          ack_a_q, ack_a_d;
  logic          ack_b_q, ack_b_d;
  logic [OW-1:0] rdata_a_q, rdata_a_d;
  logic [OW-1:0] rdata_b_q, rdata_b_d;
  logic          busy_q, busy_d;
  logic          pick_b;
`ifndef LAB4_ARB_FIXED_PRIO_EN
  logic          last_q, last_d;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    cmd_wr_d   = cmd_wr_q;
    cmd_addr_d = cmd_addr_q;
    cmd_data_d = cmd_data_q;
    cmd_op_d   = cmd_op_q;
    cmd_arg_d  = cmd_arg_q;
    ram_mode_d = 1'b0;
    ack_a_d    = 1'b0;
    ack_b_d    = 1'b0;
    rdata_a_d  = rdata_a_q;
    rdata_b_d  = rdata_b_q;
    busy_d     = 1'b0;
    pick_b     = 1'b0;
`ifndef LAB4_ARB_FIXED_PRIO_EN
    last_d     = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.reqA || bus.reqB) begin
`ifdef LAB4_ARB_FIXED_PRIO_EN
          pick_b = !bus.reqA;
`else
          pick_b = bus.reqB && (!bus.reqA || (last_q == GNT_A));
          last_d = pick_b;
`endif
          gnt_d      = pick_b;
          cmd_wr_d   = pick_b ? bus.wrB   : bus.wrA;
          cmd_addr_d = pick_b ? bus.addrB : bus.addrA;
          cmd_data_d = pick_b ? bus.dataB : bus.dataA;
          cmd_op_d   = pick_b ? bus.opB   : bus.opA;
          cmd_arg_d  = pick_b ? bus.argB  : bus.argA;
          ram_mode_d = cmd_wr_d;
          busy_d     = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // ramOutput follows the latched address, so it is sampled on the closing edge
        if (!cmd_wr_q) begin
          if (gnt_q == GNT_B) rdata_b_d = bus.ramOutput;
          else                rdata_a_d = bus.ramOutput;
        end
        ack_a_d = (gnt_q == GNT_A);
        ack_b_d = (gnt_q == GNT_B);
        busy_d  = 1'b1;
        state_d = S_ACK;
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      gnt_q      <= GNT_A;
      cmd_wr_q   <= 1'b0;
      cmd_addr_q <= '0;
      cmd_data_q <= '0;
      cmd_op_q   <= 1'b0;
      cmd_arg_q  <= '0;
      ram_mode_q <= 1'b0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      cmd_wr_q   <= cmd_wr_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_data_q <= cmd_data_d;
      cmd_op_q   <= cmd_op_d;
      cmd_arg_q  <= cmd_arg_d;
      ram_mode_q <= ram_mode_d;
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      busy_q     <= busy_d;
    end
  end

`ifndef LAB4_ARB_FIXED_PRIO_EN
  // Reset to B so that A wins the first tie
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) last_q <= GNT_B;
    else          last_q <= last_d;
  end
`endif

  assign bus.ackA     = ack_a_q;
  assign bus.ackB     = ack_b_q;
  assign bus.rdataA   = rdata_a_q;
  assign bus.rdataB   = rdata_b_q;
  assign bus.busy     = busy_q;
  assign bus.ramMode  = ram_mode_q;
  assign bus.ramAddr  = cmd_addr_q;
  assign bus.ramInput = cmd_data_q;
  assign bus.ramOp    = cmd_op_q;
  assign bus.ramArg   = cmd_arg_q;

endmodule

// File: tb/tb_lab4_ram_arbiter.sv
// Randomized bench for lab4_ram_arbiter with a transaction-level model and a stand-in lab4RAM.
// The stand-in RAM stores {op, coefficient + argument} for each written word.
module tb_lab4_ram_arbiter;

  typedef struct packed {
    logic       wr;
    logic [3:0] addr;
    logic [4:0] data;
    logic       op;
    logic [1:0] arg;
  } cmd_t;

  logic CLK;
  logic RESET_N;

  lab4_ram_arbiter_if bus ();

  lab4_ram_arbiter dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] ram_val(input logic op, input logic [1:0] arg, input logic [4:0] d);
    int a;
    case (arg)
      2'b00:   a = 1;
      2'b01:   a = 2;
      2'b10:   a = -1;
      default: a = -2;
    endcase
    return {op, 8'(int'(d) + a)};
  endfunction

  // Stand-in RAM: synchronous write, combinational read
  logic [8:0] ram [16] = '{default: '0};
  assign bus.ramOutput = ram[bus.ramAddr];
  always @(posedge CLK) begin
    if (bus.ramMode) ram[bus.ramAddr] <= ram_val(bus.ramOp, bus.ramArg, bus.ramInput);
  end

  // Reference model state
  logic [8:0] mem_m [16] = '{default: '0};
  logic [8:0] exp_rd [2];
  logic       last_m;
  logic       pend [2];
  cmd_t       pc [2];

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.wr   = 1'($urandom);
    c.addr = 4'($urandom_range(0, 7));
    c.data = 5'($urandom);
    c.op   = 1'($urandom);
    c.arg  = 2'($urandom);
    return c;
  endfunction

  function automatic cmd_t mk(input logic wr, input logic [3:0] a, input logic [4:0] d,
                              input logic op, input logic [1:0] arg);
    cmd_t c;
    c.wr = wr; c.addr = a; c.data = d; c.op = op; c.arg = arg;
    return c;
  endfunction

  task automatic drive();
    bus.reqA  = pend[0];
    bus.wrA   = pc[0].wr;
    bus.addrA = pc[0].addr;
    bus.dataA = pc[0].data;
    bus.opA   = pc[0].op;
    bus.argA  = pc[0].arg;
    bus.reqB  = pend[1];
    bus.wrB   = pc[1].wr;
    bus.addrB = pc[1].addr;
    bus.dataB = pc[1].data;
    bus.opB   = pc[1].op;
    bus.argB  = pc[1].arg;
  endtask

  task automatic model_reset();
    last_m    = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  // One arbitration slot starting in IDLE: sample, ISSUE, ACK, back to IDLE
  task automatic round(input bit drop_w, input bit keep_w);
    int   w;
    cmd_t c;
    drive();
    if (!pend[0] && !pend[1]) begin
      @(posedge CLK); #1;
      check("idle_busy", 9'(bus.busy), 9'd0);
      check("idle_mode", 9'(bus.ramMode), 9'd0);
      return;
    end
`ifdef LAB4_ARB_FIXED_PRIO_EN
    w = pend[0] ? 0 : 1;
`else
    w = (pend[0] && (!pend[1] || last_m)) ? 0 : 1;
    last_m = (w == 1);
`endif
    c = pc[w];
    @(posedge CLK); #1;
    check("issue_busy", 9'(bus.busy), 9'd1);
    check("issue_mode", 9'(bus.ramMode), 9'(c.wr));
    check("issue_addr", 9'(bus.ramAddr), 9'(c.addr));
    check("issue_in",   9'(bus.ramInput), 9'(c.data));
    check("issue_oparg", 9'({bus.ramOp, bus.ramArg}), 9'({c.op, c.arg}));
    check("issue_ack", 9'({bus.ackA, bus.ackB}), 9'd0);
    if (drop_w) begin
      pend[w] = 1'b0;
      drive();
    end
    @(posedge CLK);
    if (c.wr) mem_m[c.addr] = ram_val(c.op, c.arg, c.data);
    else      exp_rd[w] = mem_m[c.addr];
    #1;
    check("ack_a", 9'(bus.ackA), 9'(w == 0));
    check("ack_b", 9'(bus.ackB), 9'(w == 1));
    check("ack_mode", 9'(bus.ramMode), 9'd0);
    check("ack_busy", 9'(bus.busy), 9'd1);
    check("rdata_a", bus.rdataA, exp_rd[0]);
    check("rdata_b", bus.rdataB, exp_rd[1]);
    pend[w] = keep_w && !drop_w;
    if (pend[w]) pc[w] = rand_cmd();
    drive();
    @(posedge CLK); #1;
    check("post_ack", 9'({bus.ackA, bus.ackB}), 9'd0);
    check("post_busy", 9'(bus.busy), 9'd0);
  endtask

  initial begin
    RESET_N = 1'b0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    pc[0]   = '0;
    pc[1]   = '0;
    model_reset();
    drive();
    repeat (2) @(posedge CLK);
    #3;
    check("rst_busy", 9'(bus.busy), 9'd0);
    check("rst_ack", 9'({bus.ackA, bus.ackB}), 9'd0);
    check("rst_mode", 9'(bus.ramMode), 9'd0);
    check("rst_ram", 9'({bus.ramAddr, bus.ramInput}), 9'd0);
    check("rst_oparg", 9'({bus.ramOp, bus.ramArg}), 9'd0);
    check("rst_rdata_a", bus.rdataA, 9'd0);
    check("rst_rdata_b", bus.rdataB, 9'd0);
    RESET_N = 1'b1;
    @(posedge CLK); #1;

    // A writes then reads address 4
    pc[0] = mk(1'b1, 4'd4, 5'b01011, 1'b1, 2'b10); pend[0] = 1'b1;
    round(1'b0, 1'b0);
    pc[0] = mk(1'b0, 4'd4, 5'd0, 1'b0, 2'b00); pend[0] = 1'b1;
    round(1'b0, 1'b0);
    check("wr_rd_a", bus.rdataA, 9'b100001010);

    // B reads the same address; A's held result is untouched
    pc[1] = mk(1'b0, 4'd4, 5'd0, 1'b0, 2'b00); pend[1] = 1'b1;
    round(1'b0, 1'b0);
    check("iso_b", bus.rdataB, 9'b100001010);
    check("iso_a", bus.rdataA, 9'b100001010);

    // Simultaneous requests straight out of reset
    RESET_N = 1'b0; #3; RESET_N = 1'b1;
    model_reset();
    pc[0] = mk(1'b0, 4'd4, 5'd0, 1'b0, 2'b00); pend[0] = 1'b1;
    pc[1] = mk(1'b1, 4'd5, 5'd9, 1'b0, 2'b01); pend[1] = 1'b1;
    round(1'b0, 1'b0);
    round(1'b0, 1'b0);

    // Continuous contention with both requesters holding req
    pend[0] = 1'b1; pend[1] = 1'b1;
    pc[0] = rand_cmd(); pc[1] = rand_cmd();
    for (int i = 0; i < 6; i++) round(1'b0, 1'b1);
    pend[0] = 1'b0; pend[1] = 1'b0;
    round(1'b0, 1'b0);

    // Requester drops req during ISSUE
    pc[0] = mk(1'b1, 4'd2, 5'd17, 1'b0, 2'b11); pend[0] = 1'b1;
    round(1'b1, 1'b0);
    round(1'b0, 1'b0);

    // Reset asserted while a write sits in ISSUE
    pc[0] = mk(1'b1, 4'd7, 5'd3, 1'b0, 2'b00); pend[0] = 1'b1;
    round(1'b0, 1'b0);
    pc[0] = mk(1'b1, 4'd7, 5'd20, 1'b1, 2'b01); pend[0] = 1'b1;
    drive();
    @(posedge CLK); #1;
    check("abort_mode_pre", 9'(bus.ramMode), 9'd1);
    #1 RESET_N = 1'b0;
    #1;
    check("abort_mode", 9'(bus.ramMode), 9'd0);
    check("abort_busy", 9'(bus.busy), 9'd0);
    check("abort_ack", 9'({bus.ackA, bus.ackB}), 9'd0);
    check("abort_addr", 9'(bus.ramAddr), 9'd0);
    pend[0] = 1'b0;
    drive();
    model_reset();
    @(posedge CLK); #3;
    RESET_N = 1'b1;
    pc[0] = mk(1'b0, 4'd7, 5'd0, 1'b0, 2'b00); pend[0] = 1'b1;
    round(1'b0, 1'b0);
    check("abort_no_write", bus.rdataA, 9'd4);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && ($urandom_range(0, 1) == 1)) begin
          pend[r] = 1'b1;
          pc[r]   = rand_cmd();
        end
      end
      round($urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
